// File: rtl/reg_bus_arbiter_pkg.sv
// Shared definitions for the register-bus arbiter: FSM state encoding,
// default bus widths and the round-robin pointer helper.
package reg_bus_arbiter_pkg;

    // Arbiter phases: waiting for a request, transaction on the bus, one
    // enforced low cycle before the next arbitration.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int BUS_ADDR_W = 4;
    localparam int BUS_DATA_W = 4;
    localparam int CNT_W      = 8;

    // Next round-robin start position after requester idx has been served.
    function automatic int wrap_next(input int idx, input int n);
        if (idx + 1 >= n) begin
            return 0;
        end
        return idx + 1;
    endfunction

endpackage

// File: rtl/reg_bus_arbiter_if.sv
// Register bus seen by the slaves: address/data/valid strobe out, OR-ed
// ack and read data back. The arbiter is the master of this bus.
interface reg_bus_arbiter_if
    import reg_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = BUS_ADDR_W,
    parameter int DATA_W = BUS_DATA_W
);
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ack;
    logic [DATA_W-1:0] data_out;
    logic              data_out_valid;

    modport master (
        output address,
        output data,
        output valid,
        input  ack,
        input  data_out,
        input  data_out_valid
    );

    modport slave (
        input  address,
        input  data,
        input  valid,
        output ack,
        output data_out,
        output data_out_valid
    );
endinterface

// File: rtl/reg_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: returns the first set request at or
// after the pointer, wrapping around to the lower indices.
module rr_picker #(
    parameter int N_REQ = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] pick,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Two passes over the requesters: first those at or above the pointer,
    // then the ones below it, so the search wraps without modular arithmetic.
    always_comb begin
        pick = '0;
        idx  = '0;
        any  = 1'b0;
        for (int j = 0; j < N_REQ; j++) begin
            if (!any && req[j] && (j >= int'(ptr))) begin
                any     = 1'b1;
                pick[j] = 1'b1;
                idx     = IDX_W'(j);
            end
        end
        for (int j = 0; j < N_REQ; j++) begin
            if (!any && req[j] && (j < int'(ptr))) begin
                any     = 1'b1;
                pick[j] = 1'b1;
                idx     = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Shares the register bus between N_REQ requesters. One transaction at a
// time is granted round-robin; valid is held until the slaves ack or the
// timeout expires, and the completion, read data and error are returned
// to the requester that owned the bus.
module reg_bus_arbiter
    import reg_bus_arbiter_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int ADDR_W  = BUS_ADDR_W,
    parameter int DATA_W  = BUS_DATA_W,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*ADDR_W-1:0]  req_addr,
    input  logic [N_REQ*DATA_W-1:0]  req_data,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         done,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic                     timeout_err,
    reg_bus_arbiter_if.master        bus
);

    localparam int              IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   cur_idx;
    logic [CNT_W-1:0]   cnt;
    logic [ADDR_W-1:0]  address_q;
    logic [DATA_W-1:0]  data_q;
    logic               valid_q;
    logic [DATA_W-1:0]  shadow;
    logic               rd_flag;

    logic [N_REQ-1:0]   pick_onehot;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic               finish_now;

    logic [ADDR_W-1:0]  addr_slice [N_REQ];
    logic [DATA_W-1:0]  data_slice [N_REQ];

    assign bus.address = address_q;
    assign bus.data    = data_q;
    assign bus.valid   = valid_q;

    // An ack wins over a coincident timeout; either one ends the transaction.
    assign finish_now = bus.ack || (cnt == CNT_LAST);

    // Split the flattened requester buses into per-requester slices.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            addr_slice[i] = req_addr[i*ADDR_W +: ADDR_W];
            data_slice[i] = req_data[i*DATA_W +: DATA_W];
        end
    end

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req  (req),
        .ptr  (ptr),
        .pick (pick_onehot),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // Arbitration FSM with all bus and completion outputs registered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            ptr         <= '0;
            cur_idx     <= '0;
            cnt         <= '0;
            address_q   <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            shadow      <= '0;
            rd_flag     <= 1'b0;
            gnt         <= '0;
            done        <= '0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            done        <= '0;
            rd_valid    <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        gnt       <= pick_onehot;
                        cur_idx   <= pick_idx;
                        address_q <= addr_slice[pick_idx];
                        data_q    <= data_slice[pick_idx];
                        valid_q   <= 1'b1;
                        cnt       <= '0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.data_out_valid) begin
                        shadow  <= bus.data_out;
                        rd_flag <= 1'b1;
                    end
                    if (finish_now) begin
                        valid_q     <= 1'b0;
                        gnt         <= '0;
                        done        <= gnt;
                        rd_valid    <= rd_flag | bus.data_out_valid;
                        rd_data     <= bus.data_out_valid ? bus.data_out : shadow;
                        timeout_err <= !bus.ack;
                        ptr         <= IDX_W'(wrap_next(int'(cur_idx), N_REQ));
                        state       <= GAP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                GAP: begin
                    rd_flag <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Testbench for reg_bus_arbiter: a table of single-transaction vectors,
// hand-written multi-cycle sequences, and a randomized run checked against
// a transaction-level round-robin model.
module tb_reg_bus_arbiter;

    localparam int N  = 2;
    localparam int AW = 4;
    localparam int DW = 4;
    localparam int TO = 5;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic [DW-1:0]  rd_data;
    logic           rd_valid;
    logic           timeout_err;

    int checks   = 0;
    int failures = 0;

    reg_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    reg_bus_arbiter #(
        .N_REQ   (N),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .gnt         (gnt),
        .done        (done),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .timeout_err (timeout_err),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] req;
        logic [3:0] a0, d0, a1, d1;
        int         ack_delay;
        int         dov_cycle;
        logic [3:0] dov_data;
        bit         drop_req;
        logic [1:0] exp_gnt;
        logic [3:0] exp_addr, exp_data;
        int         exp_len;
        bit         exp_rdv;
        logic [3:0] exp_rdd;
        bit         exp_terr;
    } vec_t;

    typedef struct {
        bit         started, ended;
        logic [1:0] gnt;
        logic [3:0] addr, data;
        int         len;
        logic [1:0] done;
        logic       rdv;
        logic [3:0] rdd;
        logic       terr;
        logic [1:0] done_after;
        logic       valid_after;
    } act_t;

    vec_t vecs [8];
    vec_t hv;
    act_t ha;

    function automatic vec_t mkVec(logic [1:0] r, logic [3:0] a0, logic [3:0] d0,
                                   logic [3:0] a1, logic [3:0] d1, int ackd, int dovc,
                                   logic [3:0] dovd, bit drop, logic [1:0] eg,
                                   logic [3:0] ea, logic [3:0] ed, int el, bit erv,
                                   logic [3:0] erd, bit et);
        vec_t v;
        v.req = r; v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1;
        v.ack_delay = ackd; v.dov_cycle = dovc; v.dov_data = dovd; v.drop_req = drop;
        v.exp_gnt = eg; v.exp_addr = ea; v.exp_data = ed; v.exp_len = el;
        v.exp_rdv = erv; v.exp_rdd = erd; v.exp_terr = et;
        return v;
    endfunction

    // First requester at or after pointer p, wrapping; -1 when none.
    function automatic int rrPick(logic [1:0] r, int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic checkValue(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic doReset();
        rst = 1'b0;
        req = '0;
        req_addr = '0;
        req_data = '0;
        bus.ack = 1'b0;
        bus.data_out_valid = 1'b0;
        bus.data_out = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Runs one transaction from a vector, acting as the slave, and records what the DUT did.
    task automatic applyStimulus(input vec_t v, output act_t a);
        a.started = 0; a.ended = 0; a.gnt = 0; a.addr = 0; a.data = 0; a.len = 0;
        a.done = 0; a.rdv = 0; a.rdd = 0; a.terr = 0; a.done_after = 0; a.valid_after = 0;
        req_addr = {v.a1, v.a0};
        req_data = {v.d1, v.d0};
        req = v.req;
        bus.ack = 1'b0;
        bus.data_out_valid = 1'b0;
        bus.data_out = '0;
        for (int w = 0; w < 10 && !a.started; w++) begin
            @(negedge clk);
            if (bus.valid) a.started = 1;
        end
        if (!a.started) return;
        a.gnt = gnt; a.addr = bus.address; a.data = bus.data; a.len = 1;
        if (v.drop_req) req = '0;
        for (int k = 0; k < 20 && !a.ended; k++) begin
            bus.ack = (k == v.ack_delay);
            bus.data_out_valid = (k == v.dov_cycle);
            bus.data_out = (k == v.dov_cycle) ? v.dov_data : 4'h0;
            @(negedge clk);
            if (bus.valid) a.len++;
            else a.ended = 1;
        end
        bus.ack = 1'b0;
        bus.data_out_valid = 1'b0;
        bus.data_out = '0;
        if (!a.ended) return;
        a.done = done; a.rdv = rd_valid; a.rdd = rd_data; a.terr = timeout_err;
        req = '0;
        @(negedge clk);
        a.done_after = done;
        a.valid_after = bus.valid;
    endtask

    task automatic checkOutput(input string tag, input vec_t v, input act_t a);
        checkValue({tag, "_started"}, int'(a.started), 1);
        if (a.started) begin
            checkValue({tag, "_gnt"}, a.gnt, v.exp_gnt);
            checkValue({tag, "_addr"}, a.addr, v.exp_addr);
            checkValue({tag, "_data"}, a.data, v.exp_data);
            checkValue({tag, "_ended"}, int'(a.ended), 1);
            if (a.ended) begin
                checkValue({tag, "_len"}, a.len, v.exp_len);
                checkValue({tag, "_done"}, a.done, v.exp_gnt);
                checkValue({tag, "_rd_valid"}, a.rdv, int'(v.exp_rdv));
                if (v.exp_rdv) checkValue({tag, "_rd_data"}, a.rdd, v.exp_rdd);
                checkValue({tag, "_timeout_err"}, a.terr, int'(v.exp_terr));
                checkValue({tag, "_done_pulse"}, a.done_after, 0);
                checkValue({tag, "_gap_valid"}, a.valid_after, 0);
            end
        end
    endtask

    // Random requesters and slave; checks every transaction against the round-robin model.
    task automatic runRandom(input int cycles);
        int model_ptr, owner, high_len, low_len, ack_delay, exp_w, exp_len, txns, completed;
        bit rd_seen;
        logic [3:0] rd_last, own_addr, own_data;
        model_ptr = 0; owner = -1; high_len = 0; low_len = 100; ack_delay = 0;
        txns = 0; rd_seen = 0; rd_last = 0; own_addr = 0; own_data = 0;
        for (int cyc = 0; cyc < cycles; cyc++) begin
            @(negedge clk);
            completed = -1;
            if (bus.valid) begin
                if (owner < 0) begin
                    exp_w = rrPick(req, model_ptr);
                    checkValue("rand_pick_exists", (exp_w >= 0) ? 1 : 0, 1);
                    if (exp_w < 0) exp_w = 0;
                    own_addr = req_addr[exp_w*AW +: AW];
                    own_data = req_data[exp_w*DW +: DW];
                    checkValue("rand_gnt", gnt, 1 << exp_w);
                    checkValue("rand_addr", bus.address, own_addr);
                    checkValue("rand_data", bus.data, own_data);
                    checkValue("rand_gap", (low_len >= 2) ? 1 : 0, 1);
                    owner = exp_w; high_len = 1; rd_seen = 0; rd_last = 0;
                    ack_delay = int'($urandom_range(0, TO + 1));
                end else begin
                    high_len++;
                    checkValue("rand_addr_hold", bus.address, own_addr);
                    checkValue("rand_gnt_hold", gnt, 1 << owner);
                end
                checkValue("rand_no_done_busy", done, 0);
                bus.ack = ((high_len - 1) == ack_delay);
                bus.data_out_valid = ($urandom_range(0, 2) == 0);
                bus.data_out = 4'($urandom);
                if (bus.data_out_valid) begin
                    rd_seen = 1;
                    rd_last = bus.data_out;
                end
            end else begin
                if (owner >= 0) begin
                    exp_len = (ack_delay <= TO - 1) ? ack_delay + 1 : TO;
                    checkValue("rand_len", high_len, exp_len);
                    checkValue("rand_done", done, 1 << owner);
                    checkValue("rand_gnt_clear", gnt, 0);
                    checkValue("rand_timeout_err", timeout_err, (ack_delay > TO - 1) ? 1 : 0);
                    checkValue("rand_rd_valid", rd_valid, int'(rd_seen));
                    if (rd_seen) checkValue("rand_rd_data", rd_data, rd_last);
                    model_ptr = (owner + 1) % N;
                    completed = owner;
                    owner = -1;
                    low_len = 0;
                    txns++;
                end else begin
                    checkValue("rand_no_done_idle", done, 0);
                    checkValue("rand_no_rd_valid_idle", rd_valid, 0);
                    checkValue("rand_no_terr_idle", timeout_err, 0);
                end
                low_len++;
                bus.ack = ($urandom_range(0, 3) == 0);
                bus.data_out_valid = ($urandom_range(0, 3) == 0);
                bus.data_out = 4'($urandom);
            end
            for (int i = 0; i < N; i++) begin
                if (i == completed) begin
                    req[i] = 1'b0;
                end else if (!req[i] && ($urandom_range(0, 2) == 0)) begin
                    req_addr[i*AW +: AW] = 4'($urandom);
                    req_data[i*DW +: DW] = 4'($urandom);
                    req[i] = 1'b1;
                end
            end
        end
        bus.ack = 1'b0;
        bus.data_out_valid = 1'b0;
        req = '0;
        checkValue("rand_progress", (txns > 20) ? 1 : 0, 1);
    endtask

    // Hard stop in case the DUT or bench ever stalls.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence.
    initial begin
        int  exp_g;
        int  low;
        bit  seen;

        // Vectors assume the pointer starts at 0 and advances as each row completes.
        vecs[0] = mkVec(2'b01, 4'h3, 4'hA, 4'h0, 4'h0,  2, -1, 4'h0, 0, 2'b01, 4'h3, 4'hA, 3, 0, 4'h0, 0);
        vecs[1] = mkVec(2'b01, 4'h5, 4'h1, 4'h0, 4'h0,  0,  0, 4'h7, 0, 2'b01, 4'h5, 4'h1, 1, 1, 4'h7, 0);
        vecs[2] = mkVec(2'b10, 4'h0, 4'h0, 4'hC, 4'h2, 99, -1, 4'h0, 0, 2'b10, 4'hC, 4'h2, 5, 0, 4'h0, 1);
        vecs[3] = mkVec(2'b11, 4'h8, 4'h4, 4'h9, 4'h6,  4, -1, 4'h0, 0, 2'b01, 4'h8, 4'h4, 5, 0, 4'h0, 0);
        vecs[4] = mkVec(2'b11, 4'h8, 4'h4, 4'h9, 4'h6, 99,  1, 4'h9, 0, 2'b10, 4'h9, 4'h6, 5, 1, 4'h9, 1);
        vecs[5] = mkVec(2'b10, 4'h0, 4'h0, 4'h2, 4'hE,  1,  0, 4'hB, 0, 2'b10, 4'h2, 4'hE, 2, 1, 4'hB, 0);
        vecs[6] = mkVec(2'b11, 4'hF, 4'h0, 4'h1, 4'h1,  0, -1, 4'h0, 0, 2'b01, 4'hF, 4'h0, 1, 0, 4'h0, 0);
        vecs[7] = mkVec(2'b01, 4'hD, 4'h3, 4'h0, 4'h0,  2, -1, 4'h0, 1, 2'b01, 4'hD, 4'h3, 3, 0, 4'h0, 0);

        doReset();
        checkValue("reset_valid", bus.valid, 0);
        checkValue("reset_gnt", gnt, 0);
        checkValue("reset_done", done, 0);
        checkValue("reset_rd_valid", rd_valid, 0);
        checkValue("reset_timeout_err", timeout_err, 0);
        checkValue("reset_address", bus.address, 0);
        checkValue("reset_data", bus.data, 0);
        checkValue("reset_rd_data", rd_data, 0);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i], ha);
            checkOutput($sformatf("vec%0d", i), vecs[i], ha);
        end

        // Both requesters held: grants must alternate with exactly two low cycles between.
        doReset();
        req_addr = {4'h4, 4'h1};
        req_data = {4'h8, 4'h2};
        req = 2'b11;
        exp_g = 1;
        low = 0;
        for (int t = 0; t < 4; t++) begin
            seen = 0;
            for (int w = 0; w < 8 && !seen; w++) begin
                @(negedge clk);
                if (bus.valid) seen = 1;
                else low++;
            end
            checkValue($sformatf("alt%0d_seen", t), int'(seen), 1);
            if (!seen) break;
            if (t > 0) checkValue($sformatf("alt%0d_low_cycles", t), low, 2);
            checkValue($sformatf("alt%0d_gnt", t), gnt, exp_g);
            checkValue($sformatf("alt%0d_addr", t), bus.address, (exp_g == 1) ? 1 : 4);
            bus.ack = 1'b1;
            @(negedge clk);
            bus.ack = 1'b0;
            checkValue($sformatf("alt%0d_done", t), done, exp_g);
            checkValue($sformatf("alt%0d_valid_fall", t), bus.valid, 0);
            low = 1;
            exp_g = (exp_g == 1) ? 2 : 1;
        end
        req = '0;
        repeat (2) @(negedge clk);

        // Reset in the middle of a transaction: abandoned, no done, pointer back to 0.
        doReset();
        hv = mkVec(2'b01, 4'h2, 4'h3, 4'h0, 4'h0, 0, -1, 4'h0, 0, 2'b01, 4'h2, 4'h3, 1, 0, 4'h0, 0);
        applyStimulus(hv, ha);
        checkOutput("pre_reset", hv, ha);
        req_addr = {4'hA, 4'h2};
        req_data = {4'hB, 4'h3};
        req = 2'b10;
        seen = 0;
        for (int w = 0; w < 8 && !seen; w++) begin
            @(negedge clk);
            if (bus.valid) seen = 1;
        end
        checkValue("midrst_started", int'(seen), 1);
        checkValue("midrst_gnt", gnt, 2);
        @(negedge clk);
        checkValue("midrst_still_busy", bus.valid, 1);
        rst = 1'b0;
        @(negedge clk);
        checkValue("midrst_valid", bus.valid, 0);
        checkValue("midrst_gnt_clear", gnt, 0);
        checkValue("midrst_no_done", done, 0);
        rst = 1'b1;
        req = 2'b11;
        @(negedge clk);
        checkValue("midrst_after_no_done", done, 0);
        checkValue("midrst_after_valid", bus.valid, 1);
        checkValue("midrst_after_ptr_gnt", gnt, 1);
        checkValue("midrst_after_addr", bus.address, 2);
        bus.ack = 1'b1;
        @(negedge clk);
        bus.ack = 1'b0;
        req = '0;
        checkValue("midrst_after_done", done, 1);
        repeat (2) @(negedge clk);

        // Stray ack and read-valid while idle are ignored; requester 1 is served normally.
        doReset();
        bus.ack = 1'b1;
        bus.data_out_valid = 1'b1;
        bus.data_out = 4'hF;
        for (int w = 0; w < 3; w++) begin
            @(negedge clk);
            checkValue($sformatf("stray%0d_valid", w), bus.valid, 0);
            checkValue($sformatf("stray%0d_done", w), done, 0);
            checkValue($sformatf("stray%0d_rd_valid", w), rd_valid, 0);
        end
        hv = mkVec(2'b10, 4'h0, 4'h0, 4'h6, 4'h5, 1, -1, 4'h0, 0, 2'b10, 4'h6, 4'h5, 2, 0, 4'h0, 0);
        applyStimulus(hv, ha);
        checkOutput("after_stray", hv, ha);

        doReset();
        runRandom(1500);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
